// File: rtl/stack_enc_pkg.sv
// stack_enc_pkg
// Shared definitions for the stack program encoder: the 4-bit instruction
// encodings ({opcode[2:0], mod}), the encoder FSM state type and the default
// word width.
package stack_enc_pkg;

  localparam int WORD_SIZE_DEF = 32;

  localparam logic [3:0] OP_SET1 = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_DUP  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_DONE = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_DBL_DUP,
    ST_DBL_ADD,
    ST_INC,
    ST_FIN
  } state_t;

endpackage

// File: rtl/stack_enc_msb_find.sv
// stack_enc_msb_find
// Combinational priority encoder: returns the index of the highest set bit.
// An all-zero input returns 0; the caller rejects zero targets separately.
// Ports:
//   value   in   WORD_SIZE  word to scan
//   msb_idx out  IDX_W      index of the most significant 1
module stack_enc_msb_find
  import stack_enc_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int IDX_W     = $clog2(WORD_SIZE)
) (
  input  logic [WORD_SIZE-1:0] value,
  output logic [IDX_W-1:0]     msb_idx
);

  // Ascending scan: the last hit wins, so the highest set bit is reported.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (value[i]) msb_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stack_program_encoder.sv
// stack_program_encoder
// Turns a target word into the instruction stream that makes the downstream
// two-deep stack machine output that word. MSB-first double-and-add:
// SET1, then for every lower bit DUP, ADD+ and INC+ if the bit is set, then DONE.
// All outputs are registered; one instruction per cycle, no stalls.
// Optional feature: define STACK_ENC_INSN_COUNT_EN to add insn_count, the number
// of instructions emitted for the current/last program (DONE included).
// Ports:
//   clk          in   1          clock, all state on posedge
//   rst          in   1          synchronous active-high reset
//   req_valid    in   1          target presented
//   req_ready    out  1          idle, can accept (transfer = valid & ready)
//   req_target   in   WORD_SIZE  value the program must produce
//   instr        out  4          instruction to the stack machine (NOP when idle)
//   instr_valid  out  1          instr is a program instruction
//   prog_done    out  1          pulse in the cycle DONE is on instr
//   req_err      out  1          pulse: a zero target was rejected
//   insn_count   out  IDX_W+3    (STACK_ENC_INSN_COUNT_EN only) instruction count
//
// state      | meaning
// ST_IDLE    | waiting for a request, emitting NOP
// ST_SEED    | emitting SET1 (accumulator = 1 for the MSB)
// ST_DBL_DUP | emitting DUP, first half of doubling for bit b
// ST_DBL_ADD | emitting ADD+, doubling done; decide on INC for bit b
// ST_INC     | emitting INC+ because target[b] is 1
// ST_FIN     | emitting DONE with prog_done
module stack_program_encoder
  import stack_enc_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_target,
  output logic [3:0]           instr,
  output logic                 instr_valid,
  output logic                 prog_done,
`ifdef STACK_ENC_INSN_COUNT_EN
  output logic [$clog2(WORD_SIZE)+2:0] insn_count,
`endif
  output logic                 req_err
);

  localparam int IDX_W = $clog2(WORD_SIZE);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] target_q, target_d;
  logic [IDX_W-1:0]     b_q, b_d;
  logic [IDX_W-1:0]     msb_idx;
  logic                 accept;
  logic                 err_d;
  logic [3:0]           instr_d;

  stack_enc_msb_find #(
    .WORD_SIZE (WORD_SIZE),
    .IDX_W     (IDX_W)
  ) u_msb_find (
    .value   (req_target),
    .msb_idx (msb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      b_q         <= '0;
      instr       <= OP_NOP;
      instr_valid <= 1'b0;
      prog_done   <= 1'b0;
      req_err     <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      b_q         <= b_d;
      instr       <= instr_d;
      instr_valid <= (state_d != ST_IDLE);
      prog_done   <= (state_d == ST_FIN);
      req_err     <= err_d;
      req_ready   <= (state_d == ST_IDLE);
    end
  end

  // Outputs are registered copies of what the next state emits, so the
  // instruction on the bus always matches the state the FSM is in.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    b_d      = b_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_target != '0) begin
            accept   = 1'b1;
            target_d = req_target;
            b_d      = msb_idx;
            state_d  = ST_SEED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEED, ST_INC: begin
        if (b_q == '0) begin
          state_d = ST_FIN;
        end else begin
          b_d     = b_q - IDX_W'(1);
          state_d = ST_DBL_DUP;
        end
      end
      ST_DBL_DUP: state_d = ST_DBL_ADD;
      ST_DBL_ADD: begin
        if (target_q[b_q]) begin
          state_d = ST_INC;
        end else if (b_q == '0) begin
          state_d = ST_FIN;
        end else begin
          b_d     = b_q - IDX_W'(1);
          state_d = ST_DBL_DUP;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SEED:    instr_d = OP_SET1;
      ST_DBL_DUP: instr_d = OP_DUP;
      ST_DBL_ADD: instr_d = OP_ADD;
      ST_INC:     instr_d = OP_INC;
      ST_FIN:     instr_d = OP_DONE;
      default:    instr_d = OP_NOP;
    endcase
  end

`ifdef STACK_ENC_INSN_COUNT_EN
  // Counts every cycle spent outside IDLE, i.e. every emitted instruction;
  // it holds in IDLE until the next accept clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_count <= '0;
    end else if (accept) begin
      insn_count <= '0;
    end else if (state_q != ST_IDLE) begin
      insn_count <= insn_count + 1'b1;
    end
  end
`endif

endmodule
